// File: rtl/trig_probe_pkg.sv
// ============================================================================
// Module   : trig_probe_pkg
// Brief    : Shared types and constants for the trigger-probe sequencer.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package trig_probe_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SEND  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_FIN   = 2'd3
    } state_t;

    // Feedback taps x^128 + x^126 + x^101 + x^99 + 1 as a bit mask (bits 127,125,100,98)
    localparam logic [127:0] c_lfsr_taps = 128'hA000_0014_0000_0000_0000_0000_0000_0000;

    // Marker for "no vector": trig_index before any transfer, and inject_index meaning no probe
    localparam logic [7:0] c_no_vec = 8'hFF;

    function automatic logic [127:0] lfsr_next(input logic [127:0] s);
        return {s[126:0], ^(s & c_lfsr_taps)};
    endfunction

endpackage

`default_nettype wire

// File: rtl/probe_lfsr128.sv
// ============================================================================
// Module   : probe_lfsr128
// Brief    : 128-bit Fibonacci LFSR (shift left) with load and step enable.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module probe_lfsr128
    import trig_probe_pkg::*;
#(
    parameter logic [127:0] SEED = 128'h1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic         i_step,
    input  logic [127:0] i_seed,
    output logic [127:0] o_state,
    output logic [127:0] o_next
);

    logic [127:0] r_state;
    logic [127:0] w_next;

    assign w_next  = lfsr_next(r_state);
    assign o_state = r_state;
    assign o_next  = w_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= SEED;
        end else if (i_load) begin
            r_state <= i_seed;
        end else if (i_step) begin
            r_state <= w_next;
        end
    end

endmodule

`default_nettype wire

// File: rtl/trig_probe_seq.sv
// ============================================================================
// Module   : trig_probe_seq
// Brief    : Streams LFSR fill with one injected probe vector and records
//            whether / after which vector the observed trigger line fired.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module trig_probe_seq
    import trig_probe_pkg::*;
#(
    parameter int           NUM_VECTORS = 256,
    parameter logic [127:0] SEED        = 128'h0000_0000_0000_0000_0000_0000_0000_0001,
    parameter int           DRAIN       = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] probe_pattern,
    input  logic [7:0]   inject_index,
    output logic         vec_valid,
    output logic [127:0] vec_data,
    input  logic         vec_ready,
    input  logic         trig_in,
    output logic         busy,
    output logic         done,
    output logic         trig_seen,
    output logic [7:0]   trig_index
);

    localparam logic [8:0] c_num        = 9'(NUM_VECTORS);
    localparam logic [8:0] c_last       = 9'(NUM_VECTORS - 1);
    localparam logic [7:0] c_drain_last = 8'(DRAIN - 1);

    state_t       r_state,      w_state_nxt;
    logic [8:0]   r_idx,        w_idx_nxt;
    logic [7:0]   r_drain_cnt,  w_drain_cnt_nxt;
    logic [127:0] r_probe,      w_probe_nxt;
    logic [7:0]   r_inject,     w_inject_nxt;
    logic         r_vec_valid,  w_vec_valid_nxt;
    logic [127:0] r_vec_data,   w_vec_data_nxt;
    logic         r_busy,       w_busy_nxt;
    logic         r_done,       w_done_nxt;
    logic         r_trig_seen,  w_trig_seen_nxt;
    logic [7:0]   r_trig_index, w_trig_index_nxt;
    logic         w_lfsr_load;
    logic         w_lfsr_step;
    logic [127:0] w_lfsr_state;
    logic [127:0] w_lfsr_next;
    logic [8:0]   w_idx_inc;
    logic [8:0]   w_idx_dec;

    // 8'hFF never injects, even though it is a real slot when 256 vectors are sent
    function automatic logic inject_hit(input logic [8:0] slot, input logic [7:0] inj);
        return (inj != c_no_vec) && ({1'b0, inj} < c_num) && ({1'b0, inj} == slot);
    endfunction

    probe_lfsr128 #(.SEED(SEED)) u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_lfsr_load),
        .i_step  (w_lfsr_step),
        .i_seed  (SEED),
        .o_state (w_lfsr_state),
        .o_next  (w_lfsr_next)
    );

    assign w_idx_inc = r_idx + 9'd1;
    assign w_idx_dec = r_idx - 9'd1;

    always_comb begin
        w_state_nxt      = r_state;
        w_idx_nxt        = r_idx;
        w_drain_cnt_nxt  = r_drain_cnt;
        w_probe_nxt      = r_probe;
        w_inject_nxt     = r_inject;
        w_vec_valid_nxt  = r_vec_valid;
        w_vec_data_nxt   = r_vec_data;
        w_busy_nxt       = r_busy;
        w_done_nxt       = 1'b0;
        w_trig_seen_nxt  = r_trig_seen;
        w_trig_index_nxt = r_trig_index;
        w_lfsr_load      = 1'b0;
        w_lfsr_step      = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt      = ST_SEND;
                    w_probe_nxt      = probe_pattern;
                    w_inject_nxt     = inject_index;
                    w_idx_nxt        = 9'd0;
                    w_lfsr_load      = 1'b1;
                    w_vec_valid_nxt  = 1'b1;
                    w_busy_nxt       = 1'b1;
                    w_vec_data_nxt   = inject_hit(9'd0, inject_index) ? probe_pattern : SEED;
                    w_trig_seen_nxt  = 1'b0;
                    w_trig_index_nxt = 8'd0;
                end
            end
            ST_SEND: begin
                if (r_vec_valid && vec_ready) begin
                    // LFSR advances on the probe slot too, so fill is independent of inject position
                    w_lfsr_step = 1'b1;
                    w_idx_nxt   = w_idx_inc;
                    if (r_idx == c_last) begin
                        w_state_nxt     = ST_DRAIN;
                        w_vec_valid_nxt = 1'b0;
                        w_vec_data_nxt  = '0;
                        w_drain_cnt_nxt = 8'd0;
                    end else begin
                        w_vec_data_nxt = inject_hit(w_idx_inc, r_inject) ? r_probe : w_lfsr_next;
                    end
                end
            end
            ST_DRAIN: begin
                if (r_drain_cnt == c_drain_last) begin
                    w_state_nxt = ST_FIN;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_drain_cnt_nxt = r_drain_cnt + 8'd1;
                end
            end
            ST_FIN: begin
                w_state_nxt = ST_IDLE;
                w_busy_nxt  = 1'b0;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // r_idx still holds the pre-increment count when a transfer coincides with trig_in
        if ((r_state == ST_SEND || r_state == ST_DRAIN) && trig_in && !r_trig_seen) begin
            w_trig_seen_nxt  = 1'b1;
            w_trig_index_nxt = (r_idx == 9'd0) ? c_no_vec : w_idx_dec[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_idx        <= 9'd0;
            r_drain_cnt  <= 8'd0;
            r_probe      <= '0;
            r_inject     <= 8'd0;
            r_vec_valid  <= 1'b0;
            r_vec_data   <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_trig_seen  <= 1'b0;
            r_trig_index <= 8'd0;
        end else begin
            r_state      <= w_state_nxt;
            r_idx        <= w_idx_nxt;
            r_drain_cnt  <= w_drain_cnt_nxt;
            r_probe      <= w_probe_nxt;
            r_inject     <= w_inject_nxt;
            r_vec_valid  <= w_vec_valid_nxt;
            r_vec_data   <= w_vec_data_nxt;
            r_busy       <= w_busy_nxt;
            r_done       <= w_done_nxt;
            r_trig_seen  <= w_trig_seen_nxt;
            r_trig_index <= w_trig_index_nxt;
        end
    end

    assign vec_valid  = r_vec_valid;
    assign vec_data   = r_vec_data;
    assign busy       = r_busy;
    assign done       = r_done;
    assign trig_seen  = r_trig_seen;
    assign trig_index = r_trig_index;

endmodule

`default_nettype wire

// File: doc/trig_probe_seq.md
# trig_probe_seq

Directed test-vector sequencer for Trojan-trigger detection runs on the AES datapath. It streams a run of 128-bit state vectors into the block under observation: pseudo-random fill from a 128-bit LFSR, with one programmed probe pattern injected at a chosen slot. It watches a trigger/alarm line from the observed block and reports whether that line fired and which vector preceded it. It sits in the test harness between the bench controller and the AES state bus, as the driving end of the state interface that trigger logic monitors.

## Interface
- NUM_VECTORS, 256: vectors per run, range 2..256.
- SEED, 128'h0000_0000_0000_0000_0000_0000_0000_0001: LFSR seed, must be nonzero.
- DRAIN, 8: cycles trig_in keeps being observed after the last accepted vector, range 1..255.
- clk  in  1  rising-edge clock
- rst  in  1  reset rst, synchronous, active-high
- start  in  1  one-cycle run request, honoured only in IDLE
- probe_pattern  in  128  pattern injected at slot inject_index, latched on start
- inject_index  in  8  slot for the probe; latched on start; values ≥ NUM_VECTORS mean no injection
- vec_valid  out  1  vec_data is valid
- vec_data  out  128  state vector to the observed block
- vec_ready  in  1  consumer accepts; a transfer occurs when vec_valid && vec_ready
- trig_in  in  1  trigger/alarm line from the observed block
- busy  out  1  high from the cycle after start until done
- done  out  1  one-cycle pulse at end of run
- trig_seen  out  1  sticky: trig_in was high during the run
- trig_index  out  8  index of the last accepted vector when trig_in was first seen high; 8'hFF if no vector had been accepted yet

## Operation
- FSM states: IDLE → SEND → DRAIN_WAIT → FIN → IDLE.
- IDLE: start=1 latches probe_pattern and inject_index, loads LFSR=SEED, idx=0, clears trig_seen and trig_index, then goes to SEND.
- SEND: vec_valid=1. vec_data = latched probe when idx == inject_index, otherwise the LFSR value. On each transfer, idx increments and the LFSR advances one step, including on the injected slot, so the fill sequence does not depend on the inject position. The transfer at idx == NUM_VECTORS-1 moves the FSM to DRAIN_WAIT with vec_valid=0 in the next cycle.
- LFSR: Fibonacci, taps 128,126,101,99 (x^128+x^126+x^101+x^99+1), shift left, feedback into bit 0.
- DRAIN_WAIT: counts DRAIN cycles, then goes to FIN.
- FIN: done=1 for one cycle, then IDLE. trig_seen and trig_index hold until the next start.
- Trigger monitor, active in SEND and DRAIN_WAIT: on the first cycle trig_in=1, set trig_seen=1 and capture trig_index = idx-1 (8'hFF if idx==0). Later highs are ignored. trig_in in IDLE or FIN is ignored.
- start while busy is ignored.

## Timing
- Reset values: vec_valid=0, vec_data=0, busy=0, done=0, trig_seen=0, trig_index=0, FSM=IDLE, LFSR=SEED.
- rst mid-run aborts immediately to the reset values. No done pulse is produced.
- start sampled high at cycle t gives busy=1 and vec_valid=1 at t+1, with vec_data = SEED (or the probe if inject_index=0).
- With vec_ready held high: one vector per cycle, and the last transfer occurs at t+NUM_VECTORS. DRAIN_WAIT covers t+NUM_VECTORS+1 through t+NUM_VECTORS+DRAIN. done=1 at t+NUM_VECTORS+DRAIN+1, and busy=0 from the following cycle.
- Backpressure: while vec_valid=1 and vec_ready=0, vec_data, idx and the LFSR are held stable. vec_valid never drops before a transfer.
- trig_in and a transfer in the same cycle: trig_index uses idx before that transfer's increment.
- Outputs are registered. No combinational path from vec_ready or trig_in to any output.

## Structure
- Shared package trig_probe_pkg: FSM state enum, LFSR tap constant, the 8'hFF "no vector" constant.
- One sub-module, probe_lfsr128: 128-bit Fibonacci LFSR with load, seed and step enable.

## Test plan
- Probe 128'h00112233_44556677_8899aabb_ccddeeff at inject_index=5, vec_ready=1. The DUT model asserts trig_in one cycle after accepting that vector. Required: vec_data at slot 5 equals the probe, trig_seen=1, trig_index=5, done at t+NUM_VECTORS+9.
- Same run with the model never triggering: trig_seen=0, trig_index=0. Slot 0 = SEED, slot 1 = SEED<<1 (feedback 0), and vectors match a reference LFSR model.
- vec_ready toggling 1-0-0-1: vec_data and vec_valid stay stable across stalls, all NUM_VECTORS vectors are delivered exactly once, and the done time is extended by the stall count.
- inject_index=8'hFF with NUM_VECTORS=256: no slot carries the probe, and slot 255 equals the 255th LFSR step.
- start pulsed at cycle 10 of a run: ignored, with no change to idx or the LFSR. rst at cycle 20: next cycle shows vec_valid=0, busy=0, trig_seen=0, and no done pulse. A following start restarts from SEED.
- trig_in high in the cycle after start, before any transfer: trig_index=8'hFF, trig_seen=1. A second high later leaves trig_index unchanged.
